// File: rtl/rgb888_fifo_burst_sched_pkg.sv
// Shared state encoding and word-size helper for the RGB888 FIFO-to-DDR burst scheduler.
package rgb888_fifo_burst_sched_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_ARM  = S_ARM,
        ST_REQ  = S_REQ,
        ST_DATA = S_DATA,
        ST_DONE = S_DONE
    } sched_state_t;

    function automatic int bytes_per_word(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/rgb888_burst_addr_gen.sv
// Frame address / remaining-word bookkeeping and burst-length selection for the burst scheduler.
module rgb888_burst_addr_gen
    import rgb888_fifo_burst_sched_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                ADDR_W      = 32,
    parameter int                BURST_LEN   = 64,
    parameter int                FRAME_WORDS = 57600,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter int                REM_W       = $clog2(FRAME_WORDS + 1),
    parameter int                BL_W        = $clog2(BURST_LEN + 1)
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              consume,
    input  logic              advance,
    input  logic [BL_W-1:0]   adv_len,
    output logic [ADDR_W-1:0] addr,
    output logic [REM_W-1:0]  remaining,
    output logic              rem_zero,
    output logic              full_ok,
    output logic              tail_ok,
    output logic [BL_W-1:0]   burst_len
);

    localparam int                BPW       = bytes_per_word(DATA_W);
    localparam logic [ADDR_W-1:0] BPW_A     = ADDR_W'(BPW);
    localparam logic [REM_W-1:0]  BURST_REM = REM_W'(BURST_LEN);
    localparam logic [REM_W-1:0]  FRAME_REM = REM_W'(FRAME_WORDS);

    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [REM_W-1:0]  remaining_reg, remaining_next;

    always_comb begin
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        if (load) begin
            addr_next      = load_addr;
            remaining_next = FRAME_REM;
        end else begin
            if (consume) begin
                remaining_next = remaining_reg - REM_W'(1);
            end
            // Wraps modulo 2^ADDR_W by construction of the sum width.
            if (advance) begin
                addr_next = addr_reg + ADDR_W'(adv_len) * BPW_A;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg      <= RESET_ADDR;
            remaining_reg <= '0;
        end else begin
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
        end
    end

    assign addr      = addr_reg;
    assign remaining = remaining_reg;
    assign rem_zero  = (remaining_reg == '0);
    assign full_ok   = (remaining_reg >= BURST_REM);
    assign tail_ok   = !full_ok;
    assign burst_len = full_ok ? BL_W'(BURST_LEN) : BL_W'(remaining_reg);

endmodule

// File: rtl/rgb888_fifo_burst_sched.sv
// Drains the RGB888 show-ahead FIFO into DDR as fixed-length write bursts with a shortened frame tail.
// Optional macro RGB888_SCHED_PINGPONG_EN alternates frames between FRAME_BASE0 and FRAME_BASE1.
module rgb888_fifo_burst_sched
    import rgb888_fifo_burst_sched_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                ADDR_W      = 32,
    parameter int                LEN_W       = 8,
    parameter int                BURST_LEN   = 64,
    parameter int                FRAME_WORDS = 57600,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(32'h0010_0000)
) (
    input  logic              system_clk,
    input  logic              rst_n,
    input  logic              i_frame_start,
    input  logic              i_frame_end,
    input  logic              i_fifo_empty,
    input  logic              i_fifo_almost_empty,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    output logic              o_fifo_rden,
    output logic              o_wr_req,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [LEN_W-1:0]  o_wr_len,
    input  logic              i_wr_ack,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_valid,
    input  logic              i_wr_ready,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic              o_buf_sel
);

    localparam int REM_W = $clog2(FRAME_WORDS + 1);
    localparam int BL_W  = $clog2(BURST_LEN + 1);

    sched_state_t      state_reg, state_next;
    logic [BL_W-1:0]   len_reg, len_next;
    logic [BL_W-1:0]   beats_left_reg, beats_left_next;
    logic              eof_reg, eof_next;
    logic              err_reg, err_next;

    logic              load, issue, advance, beat_fire, last_beat;
    logic              buf_sel;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] gen_addr;
    logic [REM_W-1:0]  gen_remaining;
    logic              rem_zero, full_ok, tail_ok;
    logic [BL_W-1:0]   burst_len;

    rgb888_burst_addr_gen #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .RESET_ADDR  (FRAME_BASE0),
        .REM_W       (REM_W),
        .BL_W        (BL_W)
    ) u_addr_gen (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_addr  (base_addr),
        .consume    (beat_fire),
        .advance    (advance),
        .adv_len    (len_reg),
        .addr       (gen_addr),
        .remaining  (gen_remaining),
        .rem_zero   (rem_zero),
        .full_ok    (full_ok),
        .tail_ok    (tail_ok),
        .burst_len  (burst_len)
    );

    // Show-ahead FIFO: the head word is the beat, and popping it is the handshake itself.
    assign o_wr_data    = i_fifo_rddata;
    assign o_wr_valid   = (state_reg == ST_DATA) && !i_fifo_empty && (beats_left_reg != '0);
    assign beat_fire    = o_wr_valid && i_wr_ready;
    assign o_fifo_rden  = beat_fire;
    assign last_beat    = beat_fire && (beats_left_reg == BL_W'(1));
    assign o_wr_req     = (state_reg == ST_REQ);
    assign o_wr_addr    = o_wr_req ? gen_addr : '0;
    assign o_wr_len     = o_wr_req ? LEN_W'(len_reg - BL_W'(1)) : '0;
    assign o_frame_done = (state_reg == ST_DONE);
    assign o_frame_err  = err_reg;
    assign o_buf_sel    = buf_sel;

    always_comb begin
        state_next      = state_reg;
        len_next        = len_reg;
        beats_left_next = beats_left_reg;
        eof_next        = eof_reg;
        err_next        = err_reg;
        load            = 1'b0;
        issue           = 1'b0;
        advance         = 1'b0;

        if (i_frame_end && (state_reg != ST_IDLE)) begin
            eof_next = 1'b1;
        end
        if (i_frame_start && (state_reg != ST_IDLE)) begin
            err_next = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (i_frame_start) begin
                    load       = 1'b1;
                    eof_next   = 1'b0;
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                // A tail burst may only go once the producer has declared the frame complete.
                if (rem_zero) begin
                    state_next = ST_DONE;
                end else if ((full_ok && !i_fifo_almost_empty) || (eof_reg && tail_ok)) begin
                    issue           = 1'b1;
                    len_next        = burst_len;
                    beats_left_next = burst_len;
                    state_next      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_wr_ack) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat_fire) begin
                    beats_left_next = beats_left_reg - BL_W'(1);
                end
                if (last_beat) begin
                    advance    = 1'b1;
                    state_next = ST_ARM;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            len_reg        <= '0;
            beats_left_reg <= '0;
            eof_reg        <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            len_reg        <= len_next;
            beats_left_reg <= beats_left_next;
            eof_reg        <= eof_next;
            err_reg        <= err_next;
        end
    end

`ifdef RGB888_SCHED_PINGPONG_EN
    logic buf_sel_reg;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_sel_reg <= 1'b0;
        end else if (state_reg == ST_DONE) begin
            buf_sel_reg <= !buf_sel_reg;
        end
    end

    assign buf_sel   = buf_sel_reg;
    assign base_addr = buf_sel_reg ? FRAME_BASE1 : FRAME_BASE0;
`else
    logic unused_base1;

    assign unused_base1 = ^FRAME_BASE1;
    assign buf_sel      = 1'b0;
    assign base_addr    = FRAME_BASE0;
`endif

    logic unused_issue;
    assign unused_issue = issue;

endmodule

// File: tb/tb_rgb888_fifo_burst_sched.sv
// Randomized bench for rgb888_fifo_burst_sched: FIFO/DDR environment plus a frame-level burst/data model.
module tb_rgb888_fifo_burst_sched;

    localparam int          DATA_W      = 128;
    localparam int          ADDR_W      = 32;
    localparam int          LEN_W       = 8;
    localparam int          BURST_LEN   = 64;
    localparam int          FRAME_WORDS = 200;
    localparam logic [31:0] BASE0       = 32'h0000_0000;
    localparam logic [31:0] BASE1       = 32'h0010_0000;
`ifdef RGB888_SCHED_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              system_clk;
    logic              rst_n;
    logic              i_frame_start, i_frame_end;
    logic              i_fifo_empty, i_fifo_almost_empty;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              o_fifo_rden, o_wr_req, i_wr_ack, o_wr_valid, i_wr_ready;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [LEN_W-1:0]  o_wr_len;
    logic [DATA_W-1:0] o_wr_data;
    logic              o_frame_done, o_frame_err, o_buf_sel;

    rgb888_fifo_burst_sched #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .LEN_W       (LEN_W),
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .FRAME_BASE0 (BASE0),
        .FRAME_BASE1 (BASE1)
    ) dut (
        .system_clk          (system_clk),
        .rst_n               (rst_n),
        .i_frame_start       (i_frame_start),
        .i_frame_end         (i_frame_end),
        .i_fifo_empty        (i_fifo_empty),
        .i_fifo_almost_empty (i_fifo_almost_empty),
        .i_fifo_rddata       (i_fifo_rddata),
        .o_fifo_rden         (o_fifo_rden),
        .o_wr_req            (o_wr_req),
        .o_wr_addr           (o_wr_addr),
        .o_wr_len            (o_wr_len),
        .i_wr_ack            (i_wr_ack),
        .o_wr_data           (o_wr_data),
        .o_wr_valid          (o_wr_valid),
        .i_wr_ready          (i_wr_ready),
        .o_frame_done        (o_frame_done),
        .o_frame_err         (o_frame_err),
        .o_buf_sel           (o_buf_sel)
    );

    initial system_clk = 1'b0;
    always #5 system_clk = ~system_clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } req_t;

    int n_chk = 0;
    int n_err = 0;

    // Environment state
    logic [127:0] fifo_q[$];
    logic [127:0] push_log[$];
    int  prod_left = 0, prod_pct = 100, ready_pct = 100, ae_thresh = BURST_LEN, ack_wait = 0;
    bit  start_pending = 0, end_pending = 0, pop_pending = 0;

    // Model state
    req_t exp_req[$];
    int   beats_owed = 0, rd_idx = 0, frame_idx = 0, done_count = 0;
    bit   frame_active = 0, exp_err = 0, exp_buf_sel = 0;
    logic [31:0] obs_addr[4];
    logic [7:0]  obs_len[4];
    int   obs_n = 0;
    logic [31:0] f2_first_addr = 32'hdead_beef;
    bit   f2_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame as the spec describes it: full bursts from the base, then one short tail.
    task automatic build_frame(input int fidx);
        logic [31:0] a;
        int rem, n;
        a   = (PP && fidx[0]) ? BASE1 : BASE0;
        rem = FRAME_WORDS;
        while (rem > 0) begin
            req_t r;
            n      = (rem >= BURST_LEN) ? BURST_LEN : rem;
            r.addr = a;
            r.len  = 8'(n - 1);
            exp_req.push_back(r);
            a   = a + 32'(n * (DATA_W / 8));
            rem = rem - n;
        end
    endtask

    task automatic compare_cycle();
        logic fire;
        fire = o_wr_valid & i_wr_ready;
        chk("rden_eq_handshake", o_fifo_rden, fire);
        chk("frame_err", o_frame_err, exp_err);
        chk("buf_sel", o_buf_sel, exp_buf_sel);
        if (o_wr_valid) begin
            chk("valid_while_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) chk("wr_data_is_head", o_wr_data, fifo_q[0]);
        end
        if (beats_owed > 0 && fifo_q.size() > 0) chk("valid_when_data_owed", o_wr_valid, 1);
        if (o_wr_req) begin
            chk("req_expected", (beats_owed == 0) && (exp_req.size() > 0), 1);
            if (exp_req.size() > 0) begin
                chk("req_addr", o_wr_addr, exp_req[0].addr);
                chk("req_len", o_wr_len, exp_req[0].len);
            end
        end
        if (fire) begin
            chk("beat_inside_burst", beats_owed > 0, 1);
            if (rd_idx < push_log.size()) chk("beat_data_order", o_wr_data, push_log[rd_idx]);
            else chk("beat_data_extra", 1, 0);
            rd_idx++;
            if (beats_owed > 0) beats_owed--;
        end
        if (o_frame_done) begin
            chk("done_after_last_beat",
                frame_active && exp_req.size() == 0 && beats_owed == 0 && rd_idx == push_log.size(), 1);
            done_count++;
        end

        if (o_wr_req && i_wr_ack && exp_req.size() > 0) begin
            if (frame_idx == 1 && obs_n < 4) begin
                obs_addr[obs_n] = o_wr_addr;
                obs_len[obs_n]  = o_wr_len;
                obs_n++;
            end
            if (frame_idx == 2 && !f2_seen) begin
                f2_first_addr = o_wr_addr;
                f2_seen       = 1;
            end
            beats_owed = int'(exp_req[0].len) + 1;
            void'(exp_req.pop_front());
        end
        if (i_frame_start) begin
            if (frame_active) exp_err = 1;
            else begin
                frame_active = 1;
                build_frame(frame_idx);
                frame_idx++;
            end
        end
        if (o_frame_done) begin
            frame_active = 0;
            if (PP) exp_buf_sel = !exp_buf_sel;
        end
        pop_pending = o_fifo_rden;
    endtask

    task automatic drive_cycle();
        logic [127:0] w;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        i_frame_start = start_pending;
        start_pending = 0;
        i_frame_end   = end_pending;
        end_pending   = 0;
        if (prod_left > 0 && fifo_q.size() < 256 && $urandom_range(0, 99) < prod_pct) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            fifo_q.push_back(w);
            push_log.push_back(w);
            prod_left--;
            if (prod_left == 0) end_pending = 1;
        end
        i_fifo_empty        = (fifo_q.size() == 0);
        i_fifo_almost_empty = (fifo_q.size() < ae_thresh);
        i_fifo_rddata       = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        i_wr_ready          = ($urandom_range(0, 99) < ready_pct);
        if (o_wr_req) begin
            if (ack_wait == 0) begin
                i_wr_ack = 1;
                ack_wait = $urandom_range(0, 3);
            end else begin
                i_wr_ack = 0;
                ack_wait--;
            end
        end else begin
            i_wr_ack = 0;
        end
    endtask

    task automatic step();
        @(posedge system_clk);
        #1;
        drive_cycle();
        @(negedge system_clk);
        compare_cycle();
    endtask

    task automatic run_frame(input int ae, input int ppct, input int rpct, input bit stray);
        int  d0;
        bit  stray_sent;
        d0         = done_count;
        stray_sent = 0;
        ae_thresh  = ae;
        prod_pct   = ppct;
        ready_pct  = rpct;
        ack_wait   = 2;
        start_pending = 1;
        prod_left  = FRAME_WORDS;
        for (int c = 0; c < 8000 && done_count == d0; c++) begin
            step();
            if (stray && !stray_sent && o_wr_valid) begin
                start_pending = 1;
                stray_sent    = 1;
            end
        end
        if (done_count == d0) chk("frame_done_timeout", 0, 1);
        $display("frame %0d done: beats=%0d pending_reqs=%0d err=%0b buf_sel=%0b",
                 frame_idx - 1, rd_idx, exp_req.size(), o_frame_err, o_buf_sel);
        repeat (3) step();
    endtask

    initial begin
        rst_n = 0;
        i_frame_start = 0; i_frame_end = 0;
        i_fifo_empty = 1; i_fifo_almost_empty = 1; i_fifo_rddata = '0;
        i_wr_ack = 0; i_wr_ready = 0;
        repeat (2) @(posedge system_clk);
        #1;
        chk("rst_wr_req", o_wr_req, 0);
        chk("rst_wr_valid", o_wr_valid, 0);
        chk("rst_fifo_rden", o_fifo_rden, 0);
        chk("rst_frame_done", o_frame_done, 0);
        chk("rst_frame_err", o_frame_err, 0);
        chk("rst_buf_sel", o_buf_sel, 0);
        chk("rst_wr_addr", o_wr_addr, 0);
        chk("rst_wr_len", o_wr_len, 0);
        @(negedge system_clk);
        rst_n = 1;

        run_frame(BURST_LEN, 100, 100, 0);
        run_frame(8, 30, 80, 0);
        run_frame(BURST_LEN, 60, 50, 1);
        run_frame(BURST_LEN, 80, 70, 0);

        chk("lit_bursts_frame0", obs_n, 4);
        chk("lit_first_addr", obs_addr[0], 32'h0000_0000);
        chk("lit_first_len", obs_len[0], 8'd63);
        chk("lit_second_addr", obs_addr[1], 32'h0000_0400);
        chk("lit_tail_addr", obs_addr[3], 32'h0000_0C00);
        chk("lit_tail_len", obs_len[3], 8'd7);
        chk("lit_frame1_base", f2_first_addr, PP ? 32'h0010_0000 : 32'h0000_0000);
        chk("lit_err_sticky", o_frame_err, 1);

        // Reset in the middle of a burst must clear everything at once.
        ae_thresh = BURST_LEN; prod_pct = 100; ready_pct = 100;
        start_pending = 1;
        prod_left = FRAME_WORDS;
        for (int c = 0; c < 2000 && !o_wr_valid; c++) step();
        chk("midburst_valid_reached", o_wr_valid, 1);
        rst_n = 0;
        #1;
        chk("async_rst_valid", o_wr_valid, 0);
        chk("async_rst_req", o_wr_req, 0);
        chk("async_rst_err", o_frame_err, 0);
        chk("async_rst_buf_sel", o_buf_sel, 0);
        chk("async_rst_done", o_frame_done, 0);
        repeat (2) @(posedge system_clk);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rgb888_fifo_burst_sched.md
Name: rgb888_fifo_burst_sched

Overview:
- Drains the 128-bit RGB888 buffer FIFO into DDR as fixed-length write bursts.
- Watches the FIFO's almost_empty and empty flags and issues burst requests with linear frame addressing.
- Streams data with a valid/ready handshake and shortens the final burst of each frame.
- Sits between the RGB888 buffer FIFO read port and the DDR write-channel arbiter.

Parameters:
- DATA_W, 128, FIFO/DDR data width (bits); bytes per word = DATA_W/8.
- ADDR_W, 32, DDR byte-address width.
- LEN_W, 8, burst-length field width.
- BURST_LEN, 64, nominal words per burst; must equal the FIFO ALMOST_EMPTY_THRESHOLD.
- FRAME_WORDS, 57600, 128-bit words per frame (640x480x3/16).
- FRAME_BASE0, 32'h0000_0000, byte base address of frame buffer 0.
- FRAME_BASE1, 32'h0010_0000, byte base address of frame buffer 1 (used only with the optional feature).

Ports:
- system_clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_frame_start  in  1  one-cycle pulse; begin a new frame.
- i_frame_end  in  1  one-cycle pulse; producer has written the last word of the frame into the FIFO.
- i_fifo_empty  in  1  FIFO o_empty.
- i_fifo_almost_empty  in  1  FIFO o_almost_empty (fewer than BURST_LEN words held).
- i_fifo_rddata  in  DATA_W  FIFO o_rddata; show-ahead head word.
- o_fifo_rden  out  1  FIFO i_rden.
- o_wr_req  out  1  burst request.
- o_wr_addr  out  ADDR_W  burst byte address.
- o_wr_len  out  LEN_W  beats in burst minus 1.
- i_wr_ack  in  1  request accepted.
- o_wr_data  out  DATA_W  beat data.
- o_wr_valid  out  1  beat valid.
- i_wr_ready  in  1  beat accepted.
- o_frame_done  out  1  one-cycle pulse after the last beat of a frame.
- o_frame_err  out  1  sticky; i_frame_start arrived while the block was not IDLE.
- o_buf_sel  out  1  frame buffer currently being written.

Behaviour:
- Reset: state=IDLE; all outputs 0; word counter=0; address=FRAME_BASE0; eof flag=0.
- The FIFO is show-ahead: i_fifo_rddata is valid whenever i_fifo_empty=0.
- o_wr_data = i_fifo_rddata combinationally.
- o_fifo_rden = o_wr_valid & i_wr_ready, so there is zero added latency.
- States: IDLE, ARM, REQ, DATA, DONE.
- IDLE: on i_frame_start, load address=base, remaining=FRAME_WORDS, clear eof flag, go to ARM.
- ARM: issue a burst when either condition holds:
  - !i_fifo_almost_empty and remaining >= BURST_LEN: len=BURST_LEN.
  - eof flag=1 and remaining < BURST_LEN (tail): len=remaining.
  - If remaining == 0, go to DONE.
- REQ: hold o_wr_req=1 with o_wr_addr and o_wr_len stable until i_wr_ack. On the ack cycle, drop o_wr_req and go to DATA.
- DATA:
  - o_wr_valid = !i_fifo_empty & (beats_left != 0).
  - Each cycle with valid & ready: decrement beats_left and remaining.
  - After the final beat: address += len*DATA_W/8, then go to ARM.
  - An empty FIFO mid-burst only stalls (valid=0); the beat is never dropped.
- DONE: pulse o_frame_done for 1 cycle. Toggle o_buf_sel if the feature is enabled. Go to IDLE.
- i_frame_end sets the eof flag in any state except IDLE; it is cleared on frame start.
- i_frame_start outside IDLE:
  - Set o_frame_err (sticky until reset) and ignore the pulse.
  - The current frame continues.
- Arithmetic: remaining counter width = clog2(FRAME_WORDS+1). Address addition wraps modulo 2^ADDR_W.
- Simultaneous i_wr_ack and i_fifo_empty: proceed to DATA and stall there.
- Reset mid-burst: immediate return to IDLE. No partial-burst completion is owed; the DDR side is reset together with this block.

Optional Feature:
- Macro RGB888_SCHED_PINGPONG_EN.
- Defined: frames alternate between FRAME_BASE0 and FRAME_BASE1. o_buf_sel selects the base at frame start and toggles in DONE.
- Undefined: always FRAME_BASE0; o_buf_sel tied 0; FRAME_BASE1 unused.

Decomposition:
- Shared parameters include: state encoding localparams (IDLE=0, ARM=1, REQ=2, DATA=3, DONE=4) and bytes-per-word constant.
- One sub-module, rgb888_burst_addr_gen: holds address/remaining counters and computes the burst length; the FSM stays in the top.

Test Plan:
- Frame start, FIFO pre-filled with 64 words, ready=1, ack after 2 cycles -> req at addr 0x0, len=63; 64 beats with data in FIFO order; next req at 0x400.
- FRAME_WORDS=100 override, 100 words written, then i_frame_end -> bursts of len 63 and 35 at 0x0 and 0x400; single o_frame_done pulse.
- FIFO empties after beat 10 of a burst, refilled 5 cycles later -> o_wr_valid low 5 cycles; no rden while empty; 64 total beats.
- i_wr_ready toggled randomly -> o_fifo_rden equals valid&ready each cycle; no duplicated or lost words.
- i_frame_start during DATA -> o_frame_err=1 sticky; burst completes unchanged.
- With RGB888_SCHED_PINGPONG_EN, two frames -> first burst addr 0x0, second frame first burst 0x0010_0000; o_buf_sel toggles 0->1->0.
